// File: rtl/ctrl_pkg.sv
// Shared types for the pipeline control block.
// Control bundle layouts per stage, ALU op and forward-select codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_RTYPE = 3'd1,
    OP_ADDI  = 3'd2,
    OP_SLTI  = 3'd3,
    OP_BEQ   = 3'd4,
    OP_LW    = 3'd5,
    OP_SW    = 3'd6
  } aluop_e;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_e;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic       regdst;
    logic       alusrc;
    logic [2:0] aluop;
  } ctrl_t;

  typedef struct packed {
    ctrl_t      ctrl;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wr_reg;
  } id_ex_t;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic [4:0] wr_reg;
  } ex_mem_t;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic [4:0] wr_reg;
  } mem_wb_t;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] c,
    input logic        en
  );
    return (en && c != 16'hFFFF) ? c + 16'd1 : c;
  endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Datapath-facing signal bundle of the pipeline control block.
// master = datapath side, slave = ctrl_pipe.
interface ctrl_pipe_if;
  logic        id_regwrite_i;
  logic        id_alusrc_i;
  logic        id_regdst_i;
  logic        id_branch_i;
  logic        id_memread_i;
  logic        id_memwrite_i;
  logic        id_memtoreg_i;
  logic [2:0]  id_aluop_i;
  logic [4:0]  id_rs_i;
  logic [4:0]  id_rt_i;
  logic [4:0]  id_rd_i;
  logic        mem_zero_i;
  logic        pc_write_o;
  logic        ifid_write_o;
  logic        ifid_flush_o;
  logic        ex_alusrc_o;
  logic        ex_regdst_o;
  logic [2:0]  ex_aluop_o;
  logic [4:0]  ex_rs_o;
  logic [4:0]  ex_rt_o;
  logic        mem_memread_o;
  logic        mem_memwrite_o;
  logic        mem_branch_o;
  logic        branch_taken_o;
  logic        wb_regwrite_o;
  logic        wb_memtoreg_o;
  logic [4:0]  wb_wr_reg_o;
  logic [1:0]  fwd_a_o;
  logic [1:0]  fwd_b_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;

  modport master (
    output id_regwrite_i, id_alusrc_i, id_regdst_i,
    output id_branch_i, id_memread_i, id_memwrite_i,
    output id_memtoreg_i, id_aluop_i,
    output id_rs_i, id_rt_i, id_rd_i, mem_zero_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o,
    input  ex_alusrc_o, ex_regdst_o, ex_aluop_o,
    input  ex_rs_o, ex_rt_o,
    input  mem_memread_o, mem_memwrite_o, mem_branch_o,
    input  branch_taken_o,
    input  wb_regwrite_o, wb_memtoreg_o, wb_wr_reg_o,
    input  fwd_a_o, fwd_b_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_regwrite_i, id_alusrc_i, id_regdst_i,
    input  id_branch_i, id_memread_i, id_memwrite_i,
    input  id_memtoreg_i, id_aluop_i,
    input  id_rs_i, id_rt_i, id_rd_i, mem_zero_i,
    output pc_write_o, ifid_write_o, ifid_flush_o,
    output ex_alusrc_o, ex_regdst_o, ex_aluop_o,
    output ex_rs_o, ex_rt_o,
    output mem_memread_o, mem_memwrite_o, mem_branch_o,
    output branch_taken_o,
    output wb_regwrite_o, wb_memtoreg_o, wb_wr_reg_o,
    output fwd_a_o, fwd_b_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/forward_unit.sv
// ALU operand forwarding select for the EX stage.
// The nearer producer (EX/MEM) wins over MEM/WB; $0 is never forwarded.
module forward_unit
  import ctrl_pkg::*;
(
  input  logic [4:0] ex_rs_i,
  input  logic [4:0] ex_rt_i,
  input  logic       em_regwrite_i,
  input  logic [4:0] em_wr_reg_i,
  input  logic       mw_regwrite_i,
  input  logic [4:0] mw_wr_reg_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o
);

  logic em_ok;
  logic mw_ok;

  assign em_ok = em_regwrite_i && (em_wr_reg_i != 5'd0);
  assign mw_ok = mw_regwrite_i && (mw_wr_reg_i != 5'd0);

  always_comb begin
    fwd_a_o = FWD_RF;
    priority case (1'b1)
      em_ok && (em_wr_reg_i == ex_rs_i): fwd_a_o = FWD_EXMEM;
      mw_ok && (mw_wr_reg_i == ex_rs_i): fwd_a_o = FWD_MEMWB;
      default:                           fwd_a_o = FWD_RF;
    endcase
  end

  always_comb begin
    fwd_b_o = FWD_RF;
    priority case (1'b1)
      em_ok && (em_wr_reg_i == ex_rt_i): fwd_b_o = FWD_EXMEM;
      mw_ok && (mw_wr_reg_i == ex_rt_i): fwd_b_o = FWD_MEMWB;
      default:                           fwd_b_o = FWD_RF;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipeline control: ID/EX, EX/MEM, MEM/WB control registers,
// load-use stall, taken-branch flush, event counters.
module ctrl_pipe
  import ctrl_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  ctrl_pipe_if.slave   bus
);

  id_ex_t      idex_q, idex_d, id_cur;
  ex_mem_t     exmem_q, exmem_d;
  mem_wb_t     memwb_q, memwb_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        taken, load_use, flush, stall;

  always_comb begin
    id_cur               = '0;
    id_cur.ctrl.regwrite = bus.id_regwrite_i;
    id_cur.ctrl.memtoreg = bus.id_memtoreg_i;
    id_cur.ctrl.branch   = bus.id_branch_i;
    id_cur.ctrl.memread  = bus.id_memread_i;
    id_cur.ctrl.memwrite = bus.id_memwrite_i;
    id_cur.ctrl.regdst   = bus.id_regdst_i;
    id_cur.ctrl.alusrc   = bus.id_alusrc_i;
    id_cur.ctrl.aluop    = bus.id_aluop_i;
    id_cur.rs            = bus.id_rs_i;
    id_cur.rt            = bus.id_rt_i;
    id_cur.wr_reg        = bus.id_regdst_i ? bus.id_rd_i
                                           : bus.id_rt_i;
  end

  // rt only counts as a source when it feeds the ALU or store data
  assign load_use = idex_q.ctrl.memread
                 && (idex_q.rt != 5'd0)
                 && ((idex_q.rt == bus.id_rs_i)
                  || ((idex_q.rt == bus.id_rt_i)
                   && (!bus.id_alusrc_i || bus.id_memwrite_i)));

  assign taken = exmem_q.branch & bus.mem_zero_i;
  assign flush = taken && !rst_i;
  assign stall = load_use && !flush && !rst_i;

  always_comb begin
    idex_d      = (flush || stall) ? '0 : id_cur;
    exmem_d     = '0;
    memwb_d     = '0;
    if (!flush) begin
      exmem_d.regwrite = idex_q.ctrl.regwrite;
      exmem_d.memtoreg = idex_q.ctrl.memtoreg;
      exmem_d.branch   = idex_q.ctrl.branch;
      exmem_d.memread  = idex_q.ctrl.memread;
      exmem_d.memwrite = idex_q.ctrl.memwrite;
      exmem_d.wr_reg   = idex_q.wr_reg;
    end
    memwb_d.regwrite = exmem_q.regwrite;
    memwb_d.memtoreg = exmem_q.memtoreg;
    memwb_d.wr_reg   = exmem_q.wr_reg;
    stall_cnt_d = sat_inc(stall_cnt_q, stall);
    flush_cnt_d = sat_inc(flush_cnt_q, flush);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idex_q      <= '0;
      exmem_q     <= '0;
      memwb_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      idex_q      <= idex_d;
      exmem_q     <= exmem_d;
      memwb_q     <= memwb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  forward_unit u_fwd (
    .ex_rs_i       (idex_q.rs),
    .ex_rt_i       (idex_q.rt),
    .em_regwrite_i (exmem_q.regwrite),
    .em_wr_reg_i   (exmem_q.wr_reg),
    .mw_regwrite_i (memwb_q.regwrite),
    .mw_wr_reg_i   (memwb_q.wr_reg),
    .fwd_a_o       (bus.fwd_a_o),
    .fwd_b_o       (bus.fwd_b_o)
  );

  assign bus.pc_write_o     = !stall;
  assign bus.ifid_write_o   = !stall;
  assign bus.ifid_flush_o   = flush;
  assign bus.branch_taken_o = taken;
  assign bus.ex_alusrc_o    = idex_q.ctrl.alusrc;
  assign bus.ex_regdst_o    = idex_q.ctrl.regdst;
  assign bus.ex_aluop_o     = idex_q.ctrl.aluop;
  assign bus.ex_rs_o        = idex_q.rs;
  assign bus.ex_rt_o        = idex_q.rt;
  assign bus.mem_memread_o  = exmem_q.memread;
  assign bus.mem_memwrite_o = exmem_q.memwrite;
  assign bus.mem_branch_o   = exmem_q.branch;
  assign bus.wb_regwrite_o  = memwb_q.regwrite;
  assign bus.wb_memtoreg_o  = memwb_q.memtoreg;
  assign bus.wb_wr_reg_o    = memwb_q.wr_reg;
  assign bus.stall_cnt_o    = stall_cnt_q;
  assign bus.flush_cnt_o    = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: vector table per cycle plus a WB scoreboard,
// then counter saturation and reset-during-hazard sequences.
module tb_ctrl_pipe;

  typedef struct packed {
    logic       rw, as, rdst, br, mr, mw, m2r;
    logic [2:0] op;
    logic [4:0] rs, rt, rd;
  } ins_t;

  typedef struct packed {
    ins_t        i;
    logic        z;
    logic        pc;
    logic        fl;
    logic [1:0]  fa, fb;
    logic [2:0]  op;
    logic [15:0] sc, fc;
  } vec_t;

  typedef struct packed {
    logic       rw, m2r;
    logic [4:0] wr;
  } wb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ntests = 0;
  int   nfail  = 0;

  ctrl_pipe_if bus ();
  ctrl_pipe dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  function automatic ins_t i_nop();
    ins_t r = '0;
    return r;
  endfunction

  function automatic ins_t i_add(logic [4:0] s, t, d);
    ins_t r = '0;
    r.rw = 1; r.rdst = 1; r.m2r = 1; r.op = 3'd1;
    r.rs = s; r.rt = t; r.rd = d;
    return r;
  endfunction

  function automatic ins_t i_addi(logic [4:0] s, t);
    ins_t r = '0;
    r.rw = 1; r.as = 1; r.m2r = 1; r.op = 3'd2;
    r.rs = s; r.rt = t;
    return r;
  endfunction

  function automatic ins_t i_lw(logic [4:0] s, t);
    ins_t r = '0;
    r.rw = 1; r.as = 1; r.mr = 1; r.op = 3'd5;
    r.rs = s; r.rt = t;
    return r;
  endfunction

  function automatic ins_t i_sw(logic [4:0] s, t);
    ins_t r = '0;
    r.as = 1; r.mw = 1; r.op = 3'd6;
    r.rs = s; r.rt = t;
    return r;
  endfunction

  function automatic ins_t i_beq(logic [4:0] s, t);
    ins_t r = '0;
    r.br = 1; r.op = 3'd4;
    r.rs = s; r.rt = t;
    return r;
  endfunction

  function automatic ins_t i_op(logic [2:0] o);
    ins_t r = '0;
    r.op = o;
    return r;
  endfunction

  function automatic vec_t row(ins_t i, logic z, pc, fl,
                               logic [1:0] fa, fb,
                               logic [2:0] op,
                               logic [15:0] sc, fc);
    vec_t v;
    v.i = i; v.z = z; v.pc = pc; v.fl = fl;
    v.fa = fa; v.fb = fb; v.op = op;
    v.sc = sc; v.fc = fc;
    return v;
  endfunction

  function automatic wb_t wbof(ins_t i);
    wb_t w;
    w.rw  = i.rw;
    w.m2r = i.m2r;
    w.wr  = i.rdst ? i.rd : i.rt;
    return w;
  endfunction

  task automatic drive(ins_t i, logic z);
    bus.id_regwrite_i = i.rw;
    bus.id_alusrc_i   = i.as;
    bus.id_regdst_i   = i.rdst;
    bus.id_branch_i   = i.br;
    bus.id_memread_i  = i.mr;
    bus.id_memwrite_i = i.mw;
    bus.id_memtoreg_i = i.m2r;
    bus.id_aluop_i    = i.op;
    bus.id_rs_i       = i.rs;
    bus.id_rt_i       = i.rt;
    bus.id_rd_i       = i.rd;
    bus.mem_zero_i    = z;
  endtask

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam int NV = 34;
  vec_t v [NV];
  wb_t  sbq [$];
  wb_t  e;

  initial begin
    // forwarding: EX/MEM, MEM/WB, both, $0
    v[0]  = row(i_add(1,4,3),  0,1,0,2'b00,2'b00,3'd0,0,0);
    v[1]  = row(i_add(3,5,6),  0,1,0,2'b00,2'b00,3'd1,0,0);
    v[2]  = row(i_nop(),       0,1,0,2'b10,2'b00,3'd1,0,0);
    v[3]  = row(i_nop(),       0,1,0,2'b00,2'b00,3'd0,0,0);
    v[4]  = row(i_addi(0,9),   0,1,0,2'b00,2'b00,3'd0,0,0);
    v[5]  = row(i_nop(),       0,1,0,2'b00,2'b00,3'd2,0,0);
    v[6]  = row(i_add(9,9,10), 0,1,0,2'b00,2'b00,3'd0,0,0);
    v[7]  = row(i_nop(),       0,1,0,2'b01,2'b01,3'd1,0,0);
    v[8]  = row(i_add(0,0,11), 0,1,0,2'b00,2'b00,3'd0,0,0);
    v[9]  = row(i_add(0,0,11), 0,1,0,2'b00,2'b00,3'd1,0,0);
    v[10] = row(i_add(11,11,12),0,1,0,2'b00,2'b00,3'd1,0,0);
    v[11] = row(i_nop(),       0,1,0,2'b10,2'b10,3'd1,0,0);
    v[12] = row(i_add(1,2,0),  0,1,0,2'b00,2'b00,3'd0,0,0);
    v[13] = row(i_add(0,0,13), 0,1,0,2'b00,2'b00,3'd1,0,0);
    v[14] = row(i_nop(),       0,1,0,2'b00,2'b00,3'd1,0,0);
    // load-use on rs, then on store data
    v[15] = row(i_lw(0,2),     0,1,0,2'b00,2'b00,3'd0,0,0);
    v[16] = row(i_add(2,7,4),  0,0,0,2'b00,2'b00,3'd5,0,0);
    v[17] = row(i_add(2,7,4),  0,1,0,2'b00,2'b00,3'd0,1,0);
    v[18] = row(i_nop(),       0,1,0,2'b01,2'b00,3'd1,1,0);
    v[19] = row(i_lw(0,5),     0,1,0,2'b00,2'b00,3'd0,1,0);
    v[20] = row(i_sw(0,5),     0,0,0,2'b00,2'b00,3'd5,1,0);
    v[21] = row(i_sw(0,5),     0,1,0,2'b00,2'b00,3'd0,2,0);
    v[22] = row(i_lw(0,6),     0,1,0,2'b00,2'b01,3'd6,2,0);
    v[23] = row(i_addi(0,6),   0,1,0,2'b00,2'b00,3'd5,2,0);
    // taken branch
    v[24] = row(i_beq(0,0),    0,1,0,2'b00,2'b10,3'd2,2,0);
    v[25] = row(i_add(1,1,1),  0,1,0,2'b00,2'b00,3'd4,2,0);
    v[26] = row(i_add(1,1,2),  1,1,1,2'b00,2'b00,3'd1,2,0);
    v[27] = row(i_nop(),       0,1,0,2'b00,2'b00,3'd0,2,1);
    // branch taken while load-use pending
    v[28] = row(i_beq(0,0),    0,1,0,2'b00,2'b00,3'd0,2,1);
    v[29] = row(i_lw(0,3),     0,1,0,2'b00,2'b00,3'd4,2,1);
    v[30] = row(i_add(3,0,4),  1,1,1,2'b00,2'b00,3'd5,2,1);
    v[31] = row(i_nop(),       0,1,0,2'b00,2'b00,3'd0,2,2);
    v[32] = row(i_op(3'd7),    0,1,0,2'b00,2'b00,3'd0,2,2);
    v[33] = row(i_nop(),       0,1,0,2'b00,2'b00,3'd7,2,2);

    drive(i_nop(), 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst pc_write",   bus.pc_write_o, 1);
    chk("rst ifid_write", bus.ifid_write_o, 1);
    chk("rst flush",      bus.ifid_flush_o, 0);
    chk("rst ex_aluop",   bus.ex_aluop_o, 0);
    chk("rst wb_rw",      bus.wb_regwrite_o, 0);
    chk("rst wb_m2r",     bus.wb_memtoreg_o, 0);
    chk("rst stall_cnt",  bus.stall_cnt_o, 0);
    chk("rst flush_cnt",  bus.flush_cnt_o, 0);

    repeat (3) sbq.push_back('0);
    for (int k = 0; k < NV; k++) begin
      drive(v[k].i, v[k].z);
      #1;
      chk($sformatf("r%0d pc_write", k), bus.pc_write_o, v[k].pc);
      chk($sformatf("r%0d ifid_write", k),
          bus.ifid_write_o, v[k].pc);
      chk($sformatf("r%0d flush", k), bus.ifid_flush_o, v[k].fl);
      chk($sformatf("r%0d fwd_a", k), bus.fwd_a_o, v[k].fa);
      chk($sformatf("r%0d fwd_b", k), bus.fwd_b_o, v[k].fb);
      chk($sformatf("r%0d ex_aluop", k), bus.ex_aluop_o, v[k].op);
      chk($sformatf("r%0d stall_cnt", k), bus.stall_cnt_o, v[k].sc);
      chk($sformatf("r%0d flush_cnt", k), bus.flush_cnt_o, v[k].fc);
      if (v[k].fl) begin
        chk($sformatf("r%0d taken", k), bus.branch_taken_o, 1);
      end
      e = sbq.pop_front();
      chk($sformatf("r%0d wb", k),
          {bus.wb_regwrite_o, bus.wb_memtoreg_o, bus.wb_wr_reg_o}, e);
      if (v[k].fl) sbq[sbq.size()-1] = '0;
      sbq.push_back((v[k].fl || !v[k].pc) ? '0 : wbof(v[k].i));
      step();
    end

    // counter saturation
    force dut.stall_cnt_q = 16'hFFFD;
    #1;
    release dut.stall_cnt_q;
    for (int s = 0; s < 3; s++) begin
      drive(i_lw(0,2), 1'b0);
      step();
      drive(i_add(2,7,4), 1'b0);
      #1;
      chk($sformatf("sat%0d stall", s), bus.pc_write_o, 0);
      step();
      drive(i_nop(), 1'b0);
      #1;
      chk($sformatf("sat%0d stall_cnt", s), bus.stall_cnt_o,
          (s == 0) ? 32'hFFFE : 32'hFFFF);
      step();
    end

    // reset while branch flush and load-use are both pending
    drive(i_beq(0,0), 1'b0);
    step();
    drive(i_lw(0,3), 1'b0);
    step();
    drive(i_add(3,0,4), 1'b1);
    rst = 1'b1;
    #1;
    chk("mid-rst pc_write",   bus.pc_write_o, 1);
    chk("mid-rst ifid_write", bus.ifid_write_o, 1);
    chk("mid-rst flush",      bus.ifid_flush_o, 0);
    step();
    rst = 1'b0;
    drive(i_nop(), 1'b0);
    #1;
    chk("post-rst pc_write",  bus.pc_write_o, 1);
    chk("post-rst ex ctrl",
        {bus.ex_alusrc_o, bus.ex_regdst_o, bus.ex_aluop_o}, 0);
    chk("post-rst ex regs",   {bus.ex_rs_o, bus.ex_rt_o}, 0);
    chk("post-rst mem ctrl",
        {bus.mem_memread_o, bus.mem_memwrite_o, bus.mem_branch_o}, 0);
    chk("post-rst wb",
        {bus.wb_regwrite_o, bus.wb_memtoreg_o, bus.wb_wr_reg_o}, 0);
    chk("post-rst fwd",       {bus.fwd_a_o, bus.fwd_b_o}, 0);
    chk("post-rst stall_cnt", bus.stall_cnt_o, 0);
    chk("post-rst flush_cnt", bus.flush_cnt_o, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
